// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared sizing defaults and parameter helpers for the single-clock FIFO
package sfifo_pkg;
    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;
    function automatic int depth(input int asize);
        return 1 << asize;
    endfunction
    function automatic bit levels_ok(input int asize, input int af, input int ae);
        return af >= 1 && af <= depth(asize) && ae >= 0 && ae < depth(asize);
    endfunction
endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem: storage array with synchronous write and asynchronous read
module sfifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    logic [DSIZE-1:0] mem [2**ASIZE];
    // store a word only when the write was accepted
    always_ff @(posedge clk) begin
        if (wclken) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/sfifo_lvl.sv
// sfifo_lvl: single-clock FIFO with occupancy count, level thresholds, FWFT option and sticky errors
module sfifo_lvl
    import sfifo_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int ASIZE    = ASIZE_DEF,
    parameter int AF_LEVEL = depth(ASIZE_DEF) - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [ASIZE:0] ONE  = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] FULL = (ASIZE+1)'(depth(ASIZE));
    localparam logic [ASIZE:0] AF_L = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_L = (ASIZE+1)'(AE_LEVEL);

    generate
        if (!levels_ok(ASIZE, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
            $error("sfifo_lvl: AF_LEVEL/AE_LEVEL out of range");
        end
    endgenerate

    logic [ASIZE:0]   wptr, rptr, wptr_n, rptr_n, count_next;
    logic             wr_acc, rd_acc;
    logic [DSIZE-1:0] mem_rd, rdata_q;

    sfifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
        .clk   (clk),
        .wclken(wr_acc),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (mem_rd)
    );

    // accept/reject requests and derive next pointers; occupancy is the pointer distance
    always_comb begin
        wr_acc     = winc && !wfull;
        rd_acc     = rinc && !rempty;
        wptr_n     = wr_acc ? wptr + ONE : wptr;
        rptr_n     = rd_acc ? rptr + ONE : rptr;
        count_next = wptr_n - rptr_n;
    end

    // pointers, count, registered read data and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rdata_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            count     <= count_next;
            if (rd_acc) rdata_q <= mem_rd;
            overflow  <= (winc && wfull) || (overflow && !clr_err);
            underflow <= (rinc && rempty) || (underflow && !clr_err);
        end
    end

    // status flags registered from the next occupancy so they track count exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
        end else begin
            wfull         <= count_next == FULL;
            rempty        <= count_next == '0;
            walmost_full  <= count_next >= AF_L;
            ralmost_empty <= count_next <= AE_L;
        end
    end

    assign rdata = (FWFT != 0) ? mem_rd : rdata_q;
endmodule
